// File: rtl/cpu_predecode_queue.sv
`default_nettype none
// ============================================================================
// Module   : cpu_predecode_queue
// Brief    : Fetch-to-decode pre-decode stage. Extracts rs1/rs2/rs3/rd from
//            tag-stamped fetch packets and buffers them in a DEPTH-entry
//            queue behind a registered output. Optional macro
//            CPU_PREDECODE_RS3_EN enables R4 (fused multiply-add) decoding.
// Revision : 1.0 - initial release
// ============================================================================

package cpu_predecode_pkg;
    localparam int TAG_W = 8;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      pc;
        logic [31:0]      instruction;
        logic [4:0]       inst_rs1;
        logic [4:0]       inst_rs2;
        logic [4:0]       inst_rs3;
        logic [4:0]       inst_rd;
    } fetch_data_t;
endpackage

module cpu_predecode_queue
    import cpu_predecode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  fetch_data_t i_data,
    input  logic        i_flush,
    input  logic        i_ready,
    output fetch_data_t o_data,
    output logic        o_valid,
    output logic        o_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    fetch_data_t      data_q, data_d;
    logic             valid_q, valid_d;
    fetch_data_t      mem_q [DEPTH];
    fetch_data_t      mem_d [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] last_tag_q, last_tag_d;

    // Instruction-class decode on the major opcode
    logic [6:0] w_op;
    logic       w_is_b, w_is_i, w_is_r, w_is_s, w_is_u, w_is_j, w_is_csr, w_is_r4;
    assign w_op     = i_data.instruction[6:0];
    assign w_is_b   = (w_op == 7'b1100011);
    assign w_is_i   = (w_op == 7'b0000011) || (w_op == 7'b0010011) || (w_op == 7'b0011011)
                   || (w_op == 7'b1100111) || (w_op == 7'b0000111);
    assign w_is_r   = (w_op == 7'b0110011) || (w_op == 7'b0111011) || (w_op == 7'b1010011)
                   || (w_op == 7'b0101111);
    assign w_is_s   = (w_op == 7'b0100011) || (w_op == 7'b0100111);
    assign w_is_u   = (w_op == 7'b0110111) || (w_op == 7'b0010111);
    assign w_is_j   = (w_op == 7'b1101111);
    assign w_is_csr = (w_op == 7'b1110011);
`ifdef CPU_PREDECODE_RS3_EN
    assign w_is_r4  = (w_op[6:4] == 3'b100) && (w_op[1:0] == 2'b11);
`else
    assign w_is_r4  = 1'b0;
`endif

    fetch_data_t w_dec;
    always_comb begin
        w_dec          = i_data;
        w_dec.inst_rs1 = (w_is_b | w_is_i | w_is_r | w_is_s | w_is_csr | w_is_r4)
                       ? i_data.instruction[19:15] : 5'd0;
        w_dec.inst_rs2 = (w_is_b | w_is_r | w_is_s | w_is_r4)
                       ? i_data.instruction[24:20] : 5'd0;
        w_dec.inst_rs3 = w_is_r4 ? i_data.instruction[31:27] : 5'd0;
        w_dec.inst_rd  = (w_is_i | w_is_j | w_is_r | w_is_u | w_is_csr | w_is_r4)
                       ? i_data.instruction[11:7] : 5'd0;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic w_new_tag, w_busy, w_accept, w_out_free, w_bypass, w_push, w_pop;
    assign w_new_tag  = (i_data.tag != last_tag_q);
    assign w_busy     = (count_q == CNT_FULL);
    assign w_accept   = w_new_tag && !w_busy && !i_flush;
    assign w_out_free = !valid_q || i_ready;
    assign w_bypass   = w_accept && w_out_free && (count_q == '0);
    assign w_push     = w_accept && !w_bypass;
    assign w_pop      = w_out_free && (count_q != '0);

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        mem_d      = mem_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        last_tag_d = last_tag_q;

        // A redirect still consumes the incoming tag so it is not replayed later
        if (w_new_tag && (w_accept || i_flush)) begin
            last_tag_d = i_data.tag;
        end

        if (i_flush) begin
            valid_d = 1'b0;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_bypass) begin
                data_d  = w_dec;
                valid_d = 1'b1;
            end else if (w_pop) begin
                data_d  = mem_q[rptr_q];
                valid_d = 1'b1;
            end else if (w_out_free) begin
                valid_d = 1'b0;
            end

            if (w_push) begin
                mem_d[wptr_q] = w_dec;
                wptr_d        = ptr_inc(wptr_q);
            end
            if (w_pop) begin
                rptr_d = ptr_inc(rptr_q);
            end

            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            last_tag_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            last_tag_q <= last_tag_d;
            mem_q      <= mem_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = w_busy;

endmodule

`default_nettype wire

// File: doc/cpu_predecode_queue.md
# cpu_predecode_queue

Parametrised pre-decode stage with buffering, placed between fetch and decode. It accepts tag-stamped fetch packets and extracts rs1/rs2/rs3/rd indices one cycle early so that register reads overlap the full decode. Packets are held in a DEPTH-entry queue behind a registered output, with back-pressure to fetch, ready-based acceptance from decode, and a flush path for redirects.

## Interface
- DEPTH, 2: queue entries behind the output register; legal range 1..16; total capacity is DEPTH+1.
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_data  in  fetch_data_t  fetch packet; a new packet is signalled by i_data.tag differing from the last accepted tag.
- i_flush  in  1  discard all buffered and output packets (branch/trap redirect).
- i_ready  in  1  decode accepts o_data this cycle when o_valid=1.
- o_data  out  fetch_data_t  head packet, with inst_rs1/rs2/rs3/rd filled in.
- o_valid  out  1  o_data holds an unconsumed packet.
- o_busy  out  1  queue full; fetch must hold i_data unchanged.

## Operation
- Class decode uses the shared generated instruction-class signals is_B/I/R/S/U/J/CSR/R4 on i_data.instruction.
- Field rules:
  - rs1 = instr[19:15] if B|I|R|S|CSR|R4, else 0.
  - rs2 = instr[24:20] if B|R|S|R4, else 0.
  - rs3 = instr[31:27] if R4, else 0.
  - rd = instr[11:7] if I|J|R|U|CSR|R4, else 0.
  - All other fields pass through unchanged.
- Accept:
  - Condition: i_data.tag != last_tag, o_busy=0 and i_flush=0.
  - The decoded packet is written, and last_tag is set to i_data.tag.
  - A packet held while o_busy=1 keeps its tag and is accepted once o_busy falls. It is never accepted twice.
- Placement of an accepted packet:
  - It goes into the output register if the output is free and the queue is empty.
  - Otherwise it goes to the queue tail.
  - The output is free when o_valid=0, or when o_valid=1 and i_ready=1.
- Pop:
  - If the output is free and the queue is non-empty, the queue head moves into the output register and o_valid=1.
  - If the output is free and nothing is available, o_valid goes to 0. o_data keeps its last value, tag included.
- Ordering: the output order always equals the acceptance order. Bypass is only allowed when the queue is empty.
- Pointers: circular read/write pointers wrap modulo DEPTH. Occupancy count ranges 0..DEPTH.
- o_busy = (count == DEPTH). It is registered-state derived, and a same-cycle pop does not lower it.
- Flush:
  - Next cycle: count=0, pointers=0, o_valid=0.
  - A same-cycle new-tag input is dropped, but last_tag still takes its tag.
  - A same-cycle i_ready is ignored.
- Reset: o_data=0, o_valid=0, o_busy=0, count=0, pointers=0, last_tag=0. Tag value 0 is reserved and never issued by fetch after reset.

## Timing
- Latency: new tag at edge N with an empty queue and a free output gives o_valid=1 and decoded o_data after edge N.
- Throughput: 1 packet/cycle sustained while i_ready=1.
- Simultaneous accept and pop with a non-empty queue: the head moves to the output, the new packet goes to the tail, and count is unchanged.
- Full queue (count=DEPTH) with i_ready=1: the pop frees a slot. o_busy falls after that edge, and the held input is accepted one edge later.
- Back-pressure is observed from registers only. There is no combinational path i_data→o_busy or i_ready→o_busy.

## Configuration
- CPU_PREDECODE_RS3_EN:
  - Defined: is_R4 (fused multiply-add) participates in the rs1/rs2/rs3/rd rules as above.
  - Undefined: inst_rs3 is forced to 0 for all packets, and R4 is not counted in the rs1/rs2/rd rules. R4 packets then carry rs1=rs2=rd=0.
  - Queue behaviour is identical in both builds.

## Test plan
- Single packet after reset, tag 1, ADDI x5,x6,7 (0x00730293), i_ready=1 → after the next edge o_valid=1, rs1=6, rs2=0, rd=5. o_valid drops on the following edge.
- Tag held constant for 5 cycles → exactly one packet emitted. Retagging the same instruction as tag 2 → a second packet.
- DEPTH=2, i_ready=0, tags 1..4 back-to-back → o_busy=1 after the 3rd accept and tag 4 is held. Raising i_ready emits tags 1,2,3,4 in order with none lost or duplicated.
- Queue holding 2 packets, i_flush together with new tag 9 → o_valid=0 next cycle and tag 9 is never emitted. A later tag 10 is emitted with 1-cycle latency.
- FMADD.S f1,f2,f3,f4 (0x203100C3): with CPU_PREDECODE_RS3_EN rs1=2, rs2=3, rs3=4, rd=1; without it all four are 0.
- i_reset_n low for one edge mid-stream with 3 packets buffered → o_valid=0, o_busy=0 and o_data=0 after that edge. A subsequent tag 1 is accepted.
